// File: rtl/demap_rd_arbiter_if.sv
// Bundle of the estimator, equalizer and demapper read-port signals shared by the arbiter.
// The slave modport is the arbiter. The master modport is the requesters plus the demapper.
interface demap_rd_arbiter_if #(
    parameter int unsigned WIDTH_RX = 16,
    parameter int unsigned COL_W    = 4,
    parameter int unsigned ROW_W    = 4
);
    logic                est_req;
    logic                est_burst;
    logic [COL_W-1:0]    est_col;
    logic [ROW_W-1:0]    est_row;
    logic                est_gnt;
    logic                est_rd_valid;
    logic [WIDTH_RX-1:0] est_rx_r;
    logic [WIDTH_RX-1:0] est_rx_i;

    logic                eq_req;
    logic [COL_W-1:0]    eq_col;
    logic [ROW_W-1:0]    eq_row;
    logic                eq_gnt;
    logic                eq_rd_valid;
    logic [WIDTH_RX-1:0] eq_rx_r;
    logic [WIDTH_RX-1:0] eq_rx_i;

    logic                demap_rd;
    logic [COL_W-1:0]    demap_col;
    logic [ROW_W-1:0]    demap_row;
    logic [WIDTH_RX-1:0] demap_rx_r;
    logic [WIDTH_RX-1:0] demap_rx_i;

    logic                starve_evt;

    modport slave (
        input  est_req, est_burst, est_col, est_row,
        output est_gnt, est_rd_valid, est_rx_r, est_rx_i,
        input  eq_req, eq_col, eq_row,
        output eq_gnt, eq_rd_valid, eq_rx_r, eq_rx_i,
        output demap_rd, demap_col, demap_row,
        input  demap_rx_r, demap_rx_i,
        output starve_evt
    );

    modport master (
        output est_req, est_burst, est_col, est_row,
        input  est_gnt, est_rd_valid, est_rx_r, est_rx_i,
        output eq_req, eq_col, eq_row,
        input  eq_gnt, eq_rd_valid, eq_rx_r, eq_rx_i,
        input  demap_rd, demap_col, demap_row,
        output demap_rx_r, demap_rx_i,
        input  starve_evt
    );
endinterface

// File: rtl/demap_rd_arbiter.sv
// Shares the demapper read port between the channel estimator (priority, burst lock) and the
// equalizer (bounded wait). Returned samples are steered to the issuing requester by a tag pipe.
module demap_rd_arbiter #(
    parameter int unsigned WIDTH_RX = 16,
    parameter int unsigned COL_W    = 4,
    parameter int unsigned ROW_W    = 4,
    parameter int unsigned RD_LAT   = 1,
    parameter int unsigned MAX_WAIT = 8
) (
    input logic              clk,
    input logic              rst,
    demap_rd_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [0:0] {IDLE, EST_LOCK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic              wait_full;
    logic              est_gnt_c;
    logic              eq_gnt_c;
    logic              starve_c;
    logic              owner_q;
    logic [RD_LAT-1:0] tag_v;
    logic [RD_LAT-1:0] tag_own;

    assign wait_full = (wait_cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // A lock holds only while the estimator keeps presenting burst beats.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (est_gnt_c && bus.est_burst) state_nxt = EST_LOCK;
            EST_LOCK: if (!bus.est_req || !bus.est_burst) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Grants are held off while reset is asserted so every output reads 0.
    always_comb begin
        est_gnt_c = 1'b0;
        eq_gnt_c  = 1'b0;
        starve_c  = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (bus.est_req && bus.eq_req) begin
                        if (wait_full) begin
                            eq_gnt_c = 1'b1;
                            starve_c = 1'b1;
                        end else begin
                            est_gnt_c = 1'b1;
                        end
                    end else begin
                        est_gnt_c = bus.est_req;
                        eq_gnt_c  = bus.eq_req;
                    end
                end
                EST_LOCK: est_gnt_c = bus.est_req;
                default: ;
            endcase
        end
    end

    assign bus.est_gnt    = est_gnt_c;
    assign bus.eq_gnt     = eq_gnt_c;
    assign bus.starve_evt = starve_c;

    // The count saturates at MAX_WAIT, so a forced grant skipped during a lock fires on the next IDLE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          wait_cnt <= '0;
        else if (!bus.eq_req || eq_gnt_c) wait_cnt <= '0;
        else if (!wait_full)              wait_cnt <= wait_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.demap_rd  <= 1'b0;
            bus.demap_col <= '0;
            bus.demap_row <= '0;
            owner_q       <= 1'b0;
        end else begin
            bus.demap_rd <= est_gnt_c | eq_gnt_c;
            if (est_gnt_c) begin
                bus.demap_col <= bus.est_col;
                bus.demap_row <= bus.est_row;
                owner_q       <= 1'b0;
            end else if (eq_gnt_c) begin
                bus.demap_col <= bus.eq_col;
                bus.demap_row <= bus.eq_row;
                owner_q       <= 1'b1;
            end
        end
    end

    // Owner tag travels alongside the read so it lines up with the returned sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_v   <= '0;
            tag_own <= '0;
        end else begin
            tag_v[0]   <= bus.demap_rd;
            tag_own[0] <= owner_q;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                tag_v[i]   <= tag_v[i-1];
                tag_own[i] <= tag_own[i-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.est_rd_valid <= 1'b0;
            bus.est_rx_r     <= '0;
            bus.est_rx_i     <= '0;
            bus.eq_rd_valid  <= 1'b0;
            bus.eq_rx_r      <= '0;
            bus.eq_rx_i      <= '0;
        end else begin
            bus.est_rd_valid <= tag_v[RD_LAT-1] && !tag_own[RD_LAT-1];
            bus.eq_rd_valid  <= tag_v[RD_LAT-1] &&  tag_own[RD_LAT-1];
            if (tag_v[RD_LAT-1] && !tag_own[RD_LAT-1]) begin
                bus.est_rx_r <= bus.demap_rx_r;
                bus.est_rx_i <= bus.demap_rx_i;
            end
            if (tag_v[RD_LAT-1] && tag_own[RD_LAT-1]) begin
                bus.eq_rx_r <= bus.demap_rx_r;
                bus.eq_rx_i <= bus.demap_rx_i;
            end
        end
    end
endmodule
